// File: rtl/cache_controller_2way.sv
// cache_controller_2way: 2-way set-associative, write-back / write-allocate
// cache controller. It steers the SRAM mux/demux and addresses, and
// sequences line write-back and line fill against SDRAM. Each set has a
// true-LRU bit, and a dirty victim is written back before the fill.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Address_cpu, wr_rd_cpu   request address {tag,index,offset} and direction (1=write)
//   cs_cpu                   request strobe, accepted only while rdy_cpu=1
//   rdy_cpu                  1 = idle and ready for a request
//   Address_sdram            SDRAM word address
//   wr_rd_sdram              1 = write-back, 0 = fill
//   mstrb_sdram              one-cycle strobe at the start of each SDRAM word
//   mux_sel / demux_sel      SRAM data-in source / data-out sink (0=CPU, 1=SDRAM)
//   wen_sram                 SRAM write enable
//   address_cache_ctrl_sram  SRAM address {way,index,offset}
//   hit_count, miss_count    saturating counters, present only with CACHE_CTRL_PERF_CNT_EN
//
// Optional feature macro: CACHE_CTRL_PERF_CNT_EN (hit/miss counters).
// All outputs are registered. Each one is computed from the next-state values.
module cache_controller_2way #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned OFFSET_BITS = 5,
  parameter int unsigned SDRAM_LAT   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            Address_cpu,
  input  logic                             wr_rd_cpu,
  input  logic                             cs_cpu,
  output logic                             rdy_cpu,
  output logic [ADDR_WIDTH-1:0]            Address_sdram,
  output logic                             wr_rd_sdram,
  output logic                             mstrb_sdram,
  output logic                             mux_sel,
  output logic                             demux_sel,
  output logic                             wen_sram,
  output logic [INDEX_BITS+OFFSET_BITS:0]  address_cache_ctrl_sram
`ifdef CACHE_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
`endif
);

  localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned SETS     = 1 << INDEX_BITS;
  localparam int unsigned SRAM_AW  = 1 + INDEX_BITS + OFFSET_BITS;
  localparam int unsigned SUB_W    = (SDRAM_LAT < 1) ? 1 : $clog2(SDRAM_LAT + 1);

  // Reject unusable parameter values at elaboration
  if (DATA_WIDTH < 1 || SDRAM_LAT < 1) begin : g_param_check
    $error("cache_controller_2way: DATA_WIDTH and SDRAM_LAT must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_WB, S_FILL, S_ACCESS} state_t;

  state_t                   r_state, w_state_n;
  logic [ADDR_WIDTH-1:0]    r_addr, w_addr_n;
  logic                     r_wr, w_wr_n;
  logic                     r_way, w_way_n;
  logic [OFFSET_BITS-1:0]   r_word, w_word_n;
  logic [SUB_W-1:0]         r_sub, w_sub_n;
  logic [SETS-1:0][1:0]     r_valid, r_dirty;
  logic [SETS-1:0]          r_lru;
  logic [TAG_BITS-1:0]      r_tag [SETS][2];

  logic [INDEX_BITS-1:0]    w_idx, w_idx_n;
  logic [TAG_BITS-1:0]      w_tag, w_tag_n;
  logic [OFFSET_BITS-1:0]   w_off_n;
  logic                     w_hit0, w_hit1, w_hit, w_victim;
  logic                     w_last_sub, w_last_word, w_fill_done, w_access;

  logic                     w_rdy_n, w_wr_sdram_n, w_mstrb_n, w_mux_n, w_demux_n, w_wen_n;
  logic [ADDR_WIDTH-1:0]    w_sdram_addr_n;
  logic [SRAM_AW-1:0]       w_sram_addr_n;

  assign w_idx       = r_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_tag       = r_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_hit0      = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
  assign w_hit1      = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
  assign w_hit       = w_hit0 || w_hit1;
  // Victim: first invalid way (way0 first), otherwise the LRU way
  assign w_victim    = !r_valid[w_idx][0] ? 1'b0 :
                       !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
  assign w_last_sub  = (r_sub == SUB_W'(SDRAM_LAT));
  assign w_last_word = (r_word == {OFFSET_BITS{1'b1}});

  // Next-state logic
  always_comb begin
    w_state_n   = r_state;
    w_addr_n    = r_addr;
    w_wr_n      = r_wr;
    w_way_n     = r_way;
    w_word_n    = r_word;
    w_sub_n     = r_sub;
    w_fill_done = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cs_cpu) begin
          w_addr_n  = Address_cpu;
          w_wr_n    = wr_rd_cpu;
          w_state_n = S_COMPARE;
        end
      end
      S_COMPARE: begin
        w_word_n = '0;
        w_sub_n  = '0;
        if (w_hit) begin
          w_way_n   = w_hit1;
          w_state_n = S_ACCESS;
        end else begin
          w_way_n   = w_victim;
          w_state_n = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? S_WB : S_FILL;
        end
      end
      S_WB, S_FILL: begin
        if (w_last_sub) begin
          w_sub_n  = '0;
          w_word_n = r_word + OFFSET_BITS'(1);
          if (w_last_word) begin
            w_state_n   = (r_state == S_WB) ? S_FILL : S_ACCESS;
            w_fill_done = (r_state == S_FILL);
          end
        end else begin
          w_sub_n = r_sub + SUB_W'(1);
        end
      end
      S_ACCESS: begin
        w_access  = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_idx_n = w_addr_n[OFFSET_BITS +: INDEX_BITS];
  assign w_tag_n = w_addr_n[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_off_n = w_addr_n[OFFSET_BITS-1:0];

  // Output values for the state being entered. The victim tag cannot change during WB.
  always_comb begin
    w_rdy_n        = 1'b0;
    w_sdram_addr_n = '0;
    w_wr_sdram_n   = 1'b0;
    w_mstrb_n      = 1'b0;
    w_mux_n        = 1'b0;
    w_demux_n      = 1'b0;
    w_wen_n        = 1'b0;
    w_sram_addr_n  = '0;
    case (w_state_n)
      S_IDLE: w_rdy_n = 1'b1;
      S_WB: begin
        w_sram_addr_n  = {w_way_n, w_idx_n, w_word_n};
        w_demux_n      = 1'b1;
        w_sdram_addr_n = {r_tag[w_idx_n][w_way_n], w_idx_n, w_word_n};
        w_wr_sdram_n   = 1'b1;
        w_mstrb_n      = (w_sub_n == '0);
      end
      S_FILL: begin
        w_sram_addr_n  = {w_way_n, w_idx_n, w_word_n};
        w_mux_n        = 1'b1;
        w_sdram_addr_n = {w_tag_n, w_idx_n, w_word_n};
        w_mstrb_n      = (w_sub_n == '0);
        w_wen_n        = (w_sub_n == SUB_W'(SDRAM_LAT));
      end
      S_ACCESS: begin
        w_sram_addr_n = {w_way_n, w_idx_n, w_off_n};
        w_wen_n       = w_wr_n;
      end
      default: ;
    endcase
  end

  // State, per-set bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                 <= S_IDLE;
      r_addr                  <= '0;
      r_wr                    <= 1'b0;
      r_way                   <= 1'b0;
      r_word                  <= '0;
      r_sub                   <= '0;
      r_valid                 <= '0;
      r_dirty                 <= '0;
      r_lru                   <= '0;
      rdy_cpu                 <= 1'b1;
      Address_sdram           <= '0;
      wr_rd_sdram             <= 1'b0;
      mstrb_sdram             <= 1'b0;
      mux_sel                 <= 1'b0;
      demux_sel               <= 1'b0;
      wen_sram                <= 1'b0;
      address_cache_ctrl_sram <= '0;
    end else begin
      r_state                 <= w_state_n;
      r_addr                  <= w_addr_n;
      r_wr                    <= w_wr_n;
      r_way                   <= w_way_n;
      r_word                  <= w_word_n;
      r_sub                   <= w_sub_n;
      rdy_cpu                 <= w_rdy_n;
      Address_sdram           <= w_sdram_addr_n;
      wr_rd_sdram             <= w_wr_sdram_n;
      mstrb_sdram             <= w_mstrb_n;
      mux_sel                 <= w_mux_n;
      demux_sel               <= w_demux_n;
      wen_sram                <= w_wen_n;
      address_cache_ctrl_sram <= w_sram_addr_n;
      if (w_fill_done) begin
        r_valid[w_idx][r_way] <= 1'b1;
        r_dirty[w_idx][r_way] <= 1'b0;
      end
      if (w_access) begin
        if (r_wr) r_dirty[w_idx][r_way] <= 1'b1;
        r_lru[w_idx] <= ~r_way;
      end
    end
  end

  // Tags are qualified by valid, so they need no reset
  always_ff @(posedge clk) begin
    if (!rst && w_fill_done) r_tag[w_idx][r_way] <= w_tag;
  end

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;

  // Saturating hit/miss counters, one update per lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_COMPARE) begin
      if (w_hit && r_hit_cnt != 16'hFFFF)   r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (!w_hit && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_controller_2way.sv
module tb_cache_controller_2way;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Address_cpu;
  logic        wr_rd_cpu;
  logic        cs_cpu;
  logic        rdy_cpu;
  logic [15:0] Address_sdram;
  logic        wr_rd_sdram;
  logic        mstrb_sdram;
  logic        mux_sel;
  logic        demux_sel;
  logic        wen_sram;
  logic [8:0]  address_cache_ctrl_sram;
`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks = 0;
  int failures = 0;

  // Per-transaction observations
  int          t_cycles, t_fill_strb, t_wb_strb, t_fill_wen, t_seq_err, t_bad_sel;
  logic [15:0] t_fill_first, t_fill_last, t_wb_first, t_wb_last;
  logic [8:0]  t_wb_sram_first, t_acc_sram;
  logic        t_acc_wen, t_acc_mux, t_acc_demux;

  always #5 clk = ~clk;

  cache_controller_2way dut (
    .clk                     (clk),
    .rst                     (rst),
    .Address_cpu             (Address_cpu),
    .wr_rd_cpu               (wr_rd_cpu),
    .cs_cpu                  (cs_cpu),
    .rdy_cpu                 (rdy_cpu),
    .Address_sdram           (Address_sdram),
    .wr_rd_sdram             (wr_rd_sdram),
    .mstrb_sdram             (mstrb_sdram),
    .mux_sel                 (mux_sel),
    .demux_sel               (demux_sel),
    .wen_sram                (wen_sram),
    .address_cache_ctrl_sram (address_cache_ctrl_sram)
`ifdef CACHE_CTRL_PERF_CNT_EN
    ,
    .hit_count               (hit_count),
    .miss_count              (miss_count)
`endif
  );

  // Record one busy-cycle sample; the last one before rdy rises is ACCESS
  task automatic sample_busy();
    t_acc_sram  = address_cache_ctrl_sram;
    t_acc_wen   = wen_sram;
    t_acc_mux   = mux_sel;
    t_acc_demux = demux_sel;
    if (mstrb_sdram === 1'b1) begin
      if (wr_rd_sdram === 1'b1) begin
        if (t_wb_strb == 0) begin
          t_wb_first      = Address_sdram;
          t_wb_sram_first = address_cache_ctrl_sram;
        end else if (Address_sdram !== t_wb_last + 16'd1) t_seq_err++;
        t_wb_last = Address_sdram;
        t_wb_strb++;
        if (demux_sel !== 1'b1 || mux_sel !== 1'b0) t_bad_sel++;
      end else begin
        if (t_fill_strb == 0) t_fill_first = Address_sdram;
        else if (Address_sdram !== t_fill_last + 16'd1) t_seq_err++;
        t_fill_last = Address_sdram;
        t_fill_strb++;
        if (mux_sel !== 1'b1 || demux_sel !== 1'b0) t_bad_sel++;
      end
    end
    if (wen_sram === 1'b1 && mux_sel === 1'b1) t_fill_wen++;
  endtask

  // Issue one request and watch it until rdy_cpu returns (bounded)
  task automatic run_req(input logic [15:0] addr, input logic wr, input bit pulse_busy);
    @(negedge clk);
    Address_cpu = addr;
    wr_rd_cpu   = wr;
    cs_cpu      = 1'b1;
    @(posedge clk);
    #1;
    cs_cpu = 1'b0;
    t_cycles = 1; t_fill_strb = 0; t_wb_strb = 0; t_fill_wen = 0; t_seq_err = 0; t_bad_sel = 0;
    t_fill_first = '0; t_fill_last = '0; t_wb_first = '0; t_wb_last = '0;
    t_wb_sram_first = '0; t_acc_sram = '0; t_acc_wen = 0; t_acc_mux = 0; t_acc_demux = 0;
    if (rdy_cpu !== 1'b1) sample_busy();
    while (rdy_cpu !== 1'b1 && t_cycles < 400) begin
      if (pulse_busy && (t_cycles == 1 || t_cycles == 50)) begin
        Address_cpu = 16'h0000;
        wr_rd_cpu   = 1'b1;
        cs_cpu      = 1'b1;
      end
      @(posedge clk);
      #1;
      cs_cpu = 1'b0;
      t_cycles++;
      if (rdy_cpu !== 1'b1) sample_busy();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_cpu = 1'b0; wr_rd_cpu = 1'b0; Address_cpu = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy_cpu !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", rdy_cpu); end
    checks++;
    if ({mstrb_sdram, wr_rd_sdram, mux_sel, demux_sel, wen_sram} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {mstrb_sdram, wr_rd_sdram, mux_sel, demux_sel, wen_sram});
    end
    checks++;
    if (Address_sdram !== 16'h0 || address_cache_ctrl_sram !== 9'h0) begin
      failures++; $display("FAIL reset_addr got=%h/%h exp=0000/000", Address_sdram, address_cache_ctrl_sram);
    end
`ifdef CACHE_CTRL_PERF_CNT_EN
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_miss_cold();
    run_req(16'hFFE0, 1'b1, 1'b1);
    checks++; if (t_cycles != 99) begin failures++; $display("FAIL wmiss_latency got=%0d exp=99", t_cycles); end
    checks++; if (t_fill_strb != 32 || t_wb_strb != 0) begin failures++; $display("FAIL wmiss_strobes got=fill%0d/wb%0d exp=32/0", t_fill_strb, t_wb_strb); end
    checks++; if (t_fill_first !== 16'hFFE0 || t_fill_last !== 16'hFFFF) begin failures++; $display("FAIL wmiss_fill_range got=%h..%h exp=ffe0..ffff", t_fill_first, t_fill_last); end
    checks++; if (t_fill_wen != 32 || t_seq_err != 0 || t_bad_sel != 0) begin failures++; $display("FAIL wmiss_fill_cadence got=wen%0d seq%0d sel%0d exp=32/0/0", t_fill_wen, t_seq_err, t_bad_sel); end
    checks++; if (t_acc_sram !== 9'h0E0 || t_acc_wen !== 1'b1 || t_acc_mux !== 1'b0) begin failures++; $display("FAIL wmiss_access got=%h wen%b mux%b exp=0e0 wen1 mux0", t_acc_sram, t_acc_wen, t_acc_mux); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy_cpu !== 1'b1 || mstrb_sdram !== 1'b0) begin failures++; $display("FAIL busy_cs_ignored got=rdy%b mstrb%b exp=rdy1 mstrb0", rdy_cpu, mstrb_sdram); end
  endtask

  task automatic test_read_miss_way1();
    run_req(16'h9FE2, 1'b0, 1'b0);
    checks++; if (t_cycles != 99) begin failures++; $display("FAIL rmiss_latency got=%0d exp=99", t_cycles); end
    checks++; if (t_fill_strb != 32 || t_wb_strb != 0 || t_fill_first !== 16'h9FE0) begin failures++; $display("FAIL rmiss_fill got=%0d/%0d first=%h exp=32/0 9fe0", t_fill_strb, t_wb_strb, t_fill_first); end
    checks++; if (t_acc_sram !== 9'h1E2 || t_acc_wen !== 1'b0 || t_acc_demux !== 1'b0) begin failures++; $display("FAIL rmiss_access got=%h wen%b demux%b exp=1e2 wen0 demux0", t_acc_sram, t_acc_wen, t_acc_demux); end
  endtask

  task automatic test_read_hit();
    run_req(16'hFFE0, 1'b0, 1'b0);
    checks++; if (t_cycles != 3) begin failures++; $display("FAIL hit_latency got=%0d exp=3", t_cycles); end
    checks++; if (t_fill_strb + t_wb_strb != 0) begin failures++; $display("FAIL hit_no_strobe got=%0d exp=0", t_fill_strb + t_wb_strb); end
    checks++; if (t_acc_sram !== 9'h0E0 || t_acc_wen !== 1'b0) begin failures++; $display("FAIL hit_access got=%h wen%b exp=0e0 wen0", t_acc_sram, t_acc_wen); end
  endtask

`ifdef CACHE_CTRL_PERF_CNT_EN
  task automatic test_perf_counters();
    checks++;
    if (hit_count !== 16'd1 || miss_count !== 16'd2) begin
      failures++; $display("FAIL perf_counts got=%0d/%0d exp=1/2", hit_count, miss_count);
    end
  endtask
`endif

  task automatic test_clean_evict();
    run_req(16'h12E0, 1'b0, 1'b0);
    checks++; if (t_cycles != 99 || t_wb_strb != 0) begin failures++; $display("FAIL clean_evict got=%0d cyc wb%0d exp=99 wb0", t_cycles, t_wb_strb); end
    checks++; if (t_fill_first !== 16'h12E0 || t_acc_sram !== 9'h1E0) begin failures++; $display("FAIL clean_evict_way got=%h/%h exp=12e0/1e0", t_fill_first, t_acc_sram); end
    run_req(16'h12E0, 1'b1, 1'b0);
    checks++; if (t_cycles != 3 || t_acc_sram !== 9'h1E0 || t_acc_wen !== 1'b1) begin failures++; $display("FAIL write_hit_way1 got=%0d %h wen%b exp=3 1e0 wen1", t_cycles, t_acc_sram, t_acc_wen); end
    run_req(16'hFFE1, 1'b0, 1'b0);
    checks++; if (t_cycles != 3 || t_acc_sram !== 9'h0E1) begin failures++; $display("FAIL read_hit_way0 got=%0d %h exp=3 0e1", t_cycles, t_acc_sram); end
  endtask

  task automatic test_dirty_evict();
    run_req(16'h34E0, 1'b0, 1'b0);
    checks++; if (t_cycles != 195) begin failures++; $display("FAIL dirty_latency got=%0d exp=195", t_cycles); end
    checks++; if (t_wb_strb != 32 || t_wb_first !== 16'h12E0 || t_wb_last !== 16'h12FF) begin failures++; $display("FAIL dirty_wb got=%0d %h..%h exp=32 12e0..12ff", t_wb_strb, t_wb_first, t_wb_last); end
    checks++; if (t_wb_sram_first !== 9'h1E0 || t_seq_err != 0 || t_bad_sel != 0) begin failures++; $display("FAIL dirty_wb_sram got=%h seq%0d sel%0d exp=1e0 0 0", t_wb_sram_first, t_seq_err, t_bad_sel); end
    checks++; if (t_fill_strb != 32 || t_fill_first !== 16'h34E0 || t_acc_sram !== 9'h1E0) begin failures++; $display("FAIL dirty_refill got=%0d %h %h exp=32 34e0 1e0", t_fill_strb, t_fill_first, t_acc_sram); end
  endtask

  task automatic test_lru_way0_dirty();
    run_req(16'h34E0, 1'b0, 1'b0);
    checks++; if (t_cycles != 3 || t_acc_sram !== 9'h1E0) begin failures++; $display("FAIL lru_hit_way1 got=%0d %h exp=3 1e0", t_cycles, t_acc_sram); end
    run_req(16'h56E0, 1'b0, 1'b0);
    checks++; if (t_cycles != 195 || t_wb_first !== 16'hFFE0 || t_wb_last !== 16'hFFFF) begin failures++; $display("FAIL lru_evict_way0 got=%0d %h..%h exp=195 ffe0..ffff", t_cycles, t_wb_first, t_wb_last); end
    checks++; if (t_wb_sram_first !== 9'h0E0 || t_acc_sram !== 9'h0E0) begin failures++; $display("FAIL lru_evict_way0_sram got=%h/%h exp=0e0/0e0", t_wb_sram_first, t_acc_sram); end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk);
    Address_cpu = 16'h1000; wr_rd_cpu = 1'b0; cs_cpu = 1'b1;
    @(posedge clk);
    #1;
    cs_cpu = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (rdy_cpu !== 1'b0 || mux_sel !== 1'b1 || wr_rd_sdram !== 1'b0) begin failures++; $display("FAIL in_fill got=rdy%b mux%b wr%b exp=rdy0 mux1 wr0", rdy_cpu, mux_sel, wr_rd_sdram); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rdy_cpu !== 1'b1 || mstrb_sdram !== 1'b0 || mux_sel !== 1'b0 || wen_sram !== 1'b0) begin failures++; $display("FAIL rst_abort got=rdy%b mstrb%b mux%b wen%b exp=1000", rdy_cpu, mstrb_sdram, mux_sel, wen_sram); end
`ifdef CACHE_CTRL_PERF_CNT_EN
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
    run_req(16'hFFE0, 1'b0, 1'b0);
    checks++; if (t_cycles != 99 || t_wb_strb != 0 || t_acc_sram !== 9'h0E0) begin failures++; $display("FAIL post_rst_miss got=%0d wb%0d %h exp=99 wb0 0e0", t_cycles, t_wb_strb, t_acc_sram); end
    run_req(16'h1000, 1'b0, 1'b0);
    checks++; if (t_cycles != 99 || t_fill_first !== 16'h1000 || t_acc_sram !== 9'h000) begin failures++; $display("FAIL post_rst_refetch got=%0d %h %h exp=99 1000 000", t_cycles, t_fill_first, t_acc_sram); end
  endtask

  initial begin
    test_reset();
    test_write_miss_cold();
    test_read_miss_way1();
    test_read_hit();
`ifdef CACHE_CTRL_PERF_CNT_EN
    test_perf_counters();
`endif
    test_clean_evict();
    test_dirty_evict();
    test_lru_way0_dirty();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
